// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder.
//   NIBBLE_W : width of the lookahead slice processed per cycle.
//   state_e  : control FSM states (idle / busy / done).
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice.
//   a_i, b_i : 4-bit addend nibbles
//   cin_i    : carry into bit 0
//   sum_o    : 4-bit sum
//   cout_o   : carry out of bit 3
//   c3_o     : carry into bit 3 (used for signed overflow on the top nibble)
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o,
  output logic                c3_o
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is a flat sum-of-products of g/p and cin; no ripple path.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin_i);

  assign sum_o  = p ^ c[NIBBLE_W-1:0];
  assign cout_o = c[4];
  assign c3_o   = c[3];

endmodule

// File: rtl/cla_seq_adder.sv
// Serial adder: WIDTH-bit operands are summed one nibble per cycle (LSB first) through a
// single 4-bit lookahead slice with a registered inter-nibble carry.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   start_valid_i/ready_o : operand handshake; a_i, b_i, cin_i sampled on accept
//   res_valid_o/ready_i   : result handshake; sum_o, cout_o, ovf_o held while valid
// WIDTH must be a multiple of 4 and at least 8.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned Nibbles = WIDTH / NIBBLE_W;
  localparam int unsigned IdxW    = $clog2(Nibbles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Nibbles - 1);

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic               res_valid_q;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                nib_c3;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  cla4_slice u_slice (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout),
    .c3_o   (nib_c3)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry_q <= nib_cout;
          idx_q   <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            cout_q      <= nib_cout;
            ovf_q       <= nib_c3 ^ nib_cout;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by rst_i so the block never advertises readiness while held in reset.
  assign start_ready_o = (state_q == StIdle) & ~rst_i;
  assign res_valid_o   = res_valid_q;
  assign sum_o         = sum_q;
  assign cout_o        = cout_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_valid_i (start_valid),
    .start_ready_o (start_ready),
    .a_i           (a),
    .b_i           (b),
    .cin_i         (cin),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .sum_o         (sum),
    .cout_o        (cout),
    .ovf_o         (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: push expected result, drive operands, wait for result,
  // optionally stall the consumer for 'hold' cycles, then drain.
  task automatic run(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                     input int hold, input bit spam, input string tag);
    exp_t        e;
    exp_t        got;
    logic [16:0] full;
    int          cyc;
    full   = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (av[15] == bv[15]) && (full[15] != av[15]);
    sb.push_back(e);

    cyc = 0;
    while (!start_ready && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " start_ready"}, 32'(start_ready), 32'd1);
    a = av; b = bv; cin = cv; start_valid = 1'b1;
    @(posedge clk); #1;
    if (spam) begin
      a = ~av; b = av ^ 16'h5a5a; cin = ~cv; res_ready = 1'b1;
    end else begin
      start_valid = 1'b0;
    end
    check({tag, " busy start_ready"}, 32'(start_ready), 32'd0);

    cyc = 0;
    while (!res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (spam) begin
        a = 16'($urandom); b = 16'($urandom);
      end
    end
    start_valid = 1'b0;
    res_ready   = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'd4);

    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
        check({tag, " hold valid"}, 32'(res_valid), 32'd1);
        check({tag, " hold sum"}, 32'(sum), 32'(got.sum));
        check({tag, " hold cout/ovf"}, 32'({cout, ovf}), 32'({got.cout, got.ovf}));
        @(posedge clk); #1;
      end
      check({tag, " valid"}, 32'(res_valid), 32'd1);
      check({tag, " sum"}, 32'(sum), 32'(got.sum));
      check({tag, " cout"}, 32'(cout), 32'(got.cout));
      check({tag, " ovf"}, 32'(ovf), 32'(got.ovf));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, " drained valid"}, 32'(res_valid), 32'd0);
    check({tag, " idle ready"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int stray;
    rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; res_ready = 1'b0;
    #2;
    check("reset start_ready", 32'(start_ready), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset outputs", 32'({sum, cout, ovf}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post-reset start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;

    run(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "basic");
    run(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "ripple");
    run(16'h7FFF, 16'h0000, 1'b1, 0, 1'b0, "posovf");
    run(16'h8000, 16'h8000, 1'b0, 0, 1'b0, "negovf");
    run(16'hBEEF, 16'h1357, 1'b1, 5, 1'b0, "stall");
    run(16'h0F0F, 16'hF0F1, 1'b0, 0, 1'b1, "ignore");

    // Abort in the second busy cycle: nibble 0 is already written, reset must clear it.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort sum", 32'(sum), 32'd0);
    check("abort flags", 32'({res_valid, cout, ovf, start_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort ready", 32'(start_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (res_valid) stray++;
    end
    check("abort no result", 32'(stray), 32'd0);

    run(16'hA5A5, 16'h5A5B, 1'b0, 1, 1'b0, "after-abort");
    run(16'h8001, 16'hFFFF, 1'b1, 0, 1'b0, "negwrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameters: WIDTH, default 16, operand width; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start_valid  input  1  operand set is presented.
REQ-005 start_ready  output  1  block accepts operands this cycle.
REQ-006 a, b  input  WIDTH  addends; sampled only on the accept cycle.
REQ-007 cin  input  1  carry-in; sampled only on the accept cycle.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer takes the result this cycle.
REQ-010 sum  output  WIDTH  registered sum.
REQ-011 cout  output  1  unsigned carry-out of bit WIDTH-1.
REQ-012 ovf  output  1  two's-complement overflow (carry into MSB XOR cout).

Function
REQ-013 The block SHALL add WIDTH-bit operands serially, one 4-bit nibble per cycle (LSB nibble first), through a single 4-bit carry-lookahead slice with a registered inter-nibble carry.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE: start_ready=1; on start_valid & start_ready, capture a, b, cin; clear nibble index and partial sum; go to BUSY.
REQ-016 BUSY: each cycle, add nibble[idx] of a and b with the carry register; write the 4-bit result into sum[4*idx+3:4*idx]; load the slice carry-out into the carry register; increment idx.
REQ-017 BUSY -> DONE on the cycle idx = WIDTH/4-1 completes; cout = slice carry-out of that cycle; ovf = (carry into bit WIDTH-1) XOR cout, registered in the same cycle.
REQ-018 Latency: accept at edge N -> res_valid=1 after edge N+WIDTH/4 (4 cycles for WIDTH=16).
REQ-019 DONE: res_valid=1; sum, cout, ovf SHALL hold stable until res_valid & res_ready.
REQ-020 DONE & res_ready -> IDLE at that edge; res_valid deasserts the next cycle; no same-cycle re-accept (start_ready=0 in DONE).
REQ-021 start_ready=0 in BUSY and DONE; start_valid there SHALL be ignored and SHALL NOT disturb the captured operands.
REQ-022 res_ready while not in DONE SHALL have no effect.
REQ-023 sum bits not yet computed in BUSY are 0; only the value presented while res_valid=1 is defined for consumers.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Reset
REQ-025 rst asserted SHALL force, without waiting for clk: state=IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, res_valid=0.
REQ-026 start_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-027 rst asserted in BUSY or DONE SHALL abort the operation; that result SHALL never be presented.

Structure
REQ-028 Shared package cla_pkg SHALL hold the state enum type (IDLE, BUSY, DONE) and the constant NIBBLE_W=4.
REQ-029 One sub-module, cla4_slice, SHALL implement the 4-bit generate/propagate lookahead (inputs: 4-bit a, 4-bit b, cin; outputs: 4-bit sum, cout, carry into bit 3); it is instantiated once.
REQ-030 The index counter width SHALL be $clog2(WIDTH/4).

Verification (WIDTH=16)
REQ-031 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0, res_valid 4 cycles after accept.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all four nibbles).
REQ-033 a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
REQ-034 res_ready held 0 for 5 cycles in DONE -> res_valid, sum, cout, ovf unchanged; then res_ready=1 -> IDLE and start_ready=1 the next cycle.
REQ-035 start_valid=1 with new operands throughout BUSY -> ignored; result equals the first accepted operands.
REQ-036 rst pulse in the 2nd BUSY cycle -> outputs zero immediately; no res_valid; a new transaction after release completes correctly.
